// File: rtl/uart_pkg.sv
// Shared types and constants for the UART blocks.
package uart_pkg;

    localparam int CLKS_PER_BIT_115200_30MHZ = 260;
    localparam int UART_DATA_BITS            = 8;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP,
        BREAK
    } uart_rx_state_e;

endpackage

// File: rtl/uart_sync2.sv
// Two-flop synchroniser for an asynchronous single-bit input, with a
// configurable reset value so idle-high and idle-low lines both come up quiet.
module uart_sync2 #(
    parameter logic RESET_VAL = 1'b1
) (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk) begin
        if (reset) begin
            meta <= RESET_VAL;
            q    <= RESET_VAL;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/uart_receiver.sv
// 8N1 UART receiver with a one-entry valid/ready holding register.
// Define UART_RX_PARITY_EN to add a parity bit (polarity via PARITY_ODD).
module uart_receiver
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = CLKS_PER_BIT_115200_30MHZ
`ifdef UART_RX_PARITY_EN
    , parameter bit PARITY_ODD = 1'b0
`endif
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rx,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic       rx_ready,
    output logic       frame_err,
    output logic       overrun_err,
    output logic       parity_err,
    output logic       busy
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] BIT_RELOAD  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] HALF_RELOAD = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [2:0]       LAST_BIT    = 3'(UART_DATA_BITS - 1);

    uart_rx_state_e             state, state_nxt;
    logic [CNT_W-1:0]           cnt, cnt_nxt;
    logic [2:0]                 bit_idx, bit_idx_nxt;
    logic [UART_DATA_BITS-1:0]  shift, shift_nxt;
    logic                       stop_ok, stop_ok_nxt;
    logic                       stop_bad, stop_bad_nxt;
    logic                       rxs;
    logic                       tick;

    uart_sync2 #(.RESET_VAL(1'b1)) u_sync (
        .clk   (clk),
        .reset (reset),
        .d     (rx),
        .q     (rxs)
    );

    assign tick = (cnt == '0);
    assign busy = (state != IDLE);

`ifdef UART_RX_PARITY_EN
    logic perr_flag, perr_flag_nxt;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            cnt      <= '0;
            bit_idx  <= '0;
            shift    <= '0;
            stop_ok  <= 1'b0;
            stop_bad <= 1'b0;
`ifdef UART_RX_PARITY_EN
            perr_flag <= 1'b0;
`endif
        end else begin
            state    <= state_nxt;
            cnt      <= cnt_nxt;
            bit_idx  <= bit_idx_nxt;
            shift    <= shift_nxt;
            stop_ok  <= stop_ok_nxt;
            stop_bad <= stop_bad_nxt;
`ifdef UART_RX_PARITY_EN
            perr_flag <= perr_flag_nxt;
`endif
        end
    end

    always_comb begin
        state_nxt    = state;
        cnt_nxt      = cnt;
        bit_idx_nxt  = bit_idx;
        shift_nxt    = shift;
        stop_ok_nxt  = 1'b0;
        stop_bad_nxt = 1'b0;
`ifdef UART_RX_PARITY_EN
        perr_flag_nxt = perr_flag;
`endif
        case (state)
            IDLE: begin
                if (!rxs) begin
                    state_nxt = START;
                    cnt_nxt   = HALF_RELOAD;
                end
            end
            START: begin
                if (!tick) begin
                    cnt_nxt = cnt - CNT_W'(1);
                end else if (!rxs) begin
                    state_nxt   = DATA;
                    cnt_nxt     = BIT_RELOAD;
                    bit_idx_nxt = '0;
                end else begin
                    state_nxt = IDLE;
                end
            end
            DATA: begin
                if (!tick) begin
                    cnt_nxt = cnt - CNT_W'(1);
                end else begin
                    shift_nxt   = {rxs, shift[UART_DATA_BITS-1:1]};
                    cnt_nxt     = BIT_RELOAD;
                    bit_idx_nxt = bit_idx + 3'd1;
                    if (bit_idx == LAST_BIT) begin
`ifdef UART_RX_PARITY_EN
                        state_nxt = PARITY;
`else
                        state_nxt = STOP;
`endif
                    end
                end
            end
`ifdef UART_RX_PARITY_EN
            PARITY: begin
                if (!tick) begin
                    cnt_nxt = cnt - CNT_W'(1);
                end else begin
                    // Mismatch when data XOR parity bit disagrees with the configured polarity
                    perr_flag_nxt = rxs ^ (^shift) ^ PARITY_ODD;
                    cnt_nxt       = BIT_RELOAD;
                    state_nxt     = STOP;
                end
            end
`endif
            STOP: begin
                if (!tick) begin
                    cnt_nxt = cnt - CNT_W'(1);
                end else if (rxs) begin
                    stop_ok_nxt = 1'b1;
                    state_nxt   = IDLE;
                end else begin
                    stop_bad_nxt = 1'b1;
                    state_nxt    = BREAK;
                end
            end
            BREAK: begin
                if (rxs) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Holding register: a new byte wins over a same-cycle acceptance of the old one.
    always_ff @(posedge clk) begin
        if (reset) begin
            rx_data     <= '0;
            rx_valid    <= 1'b0;
            frame_err   <= 1'b0;
            overrun_err <= 1'b0;
        end else begin
            frame_err   <= stop_bad;
            overrun_err <= 1'b0;
            if (stop_ok && (!rx_valid || rx_ready)) begin
                rx_data  <= shift;
                rx_valid <= 1'b1;
            end else begin
                if (rx_valid && rx_ready) rx_valid <= 1'b0;
                if (stop_ok) overrun_err <= 1'b1;
            end
        end
    end

`ifdef UART_RX_PARITY_EN
    always_ff @(posedge clk) begin
        if (reset) parity_err <= 1'b0;
        else       parity_err <= stop_ok & perr_flag;
    end
`else
    assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_uart_receiver.sv
// Self-checking bench for uart_receiver: frame-level model with a per-cycle comparator.
module tb_uart_receiver;

    localparam int CPB = 260;
`ifdef UART_RX_PARITY_EN
    localparam int LAT = 2 + CPB/2 + 10*CPB + 2;
`else
    localparam int LAT = 2 + CPB/2 + 9*CPB + 2;
`endif
    localparam int N = 1 << 17;

    logic       clk      = 1'b0;
    logic       reset    = 1'b1;
    logic       rx       = 1'b1;
    logic       rx_ready = 1'b1;
    logic [7:0] rx_data;
    logic       rx_valid, frame_err, overrun_err, parity_err, busy;

    uart_receiver #(.CLKS_PER_BIT(CPB)) dut (
        .clk         (clk),
        .reset       (reset),
        .rx          (rx),
        .rx_data     (rx_data),
        .rx_valid    (rx_valid),
        .rx_ready    (rx_ready),
        .frame_err   (frame_err),
        .overrun_err (overrun_err),
        .parity_err  (parity_err),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    // Frame outcomes scheduled by the driver at their nominal cycle (1 = byte, 2 = framing error)
    bit [1:0] ev_kind [N];
    bit [7:0] ev_byte [N];
    bit       ev_perr [N];
    bit       blk     [N];
    // Pulse bookkeeping: k = 0 frame_err, 1 overrun_err, 2 parity_err
    bit       exp_p [3][N];
    bit       hist  [3][N];
    bit       used  [3][N];
    int       pcnt  [3] = '{0, 0, 0};
    string    pname [3] = '{"frame_err", "overrun_err", "parity_err"};

    logic       m_valid = 1'b0;
    logic [7:0] m_data  = 8'h00;
    logic       prev_valid = 1'b0;
    int         rises = 0;
    int         rise_cyc = 0;
    logic [7:0] last_rx = 8'h00;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Model: holding register behaviour at frame granularity
    always @(posedge clk) begin
        bit load;
        cyc = cyc + 1;
        if (reset) begin
            m_valid = 1'b0;
            m_data  = 8'h00;
        end else if (cyc < N) begin
            load = 1'b0;
            if (ev_kind[cyc] == 2'd1) begin
                if (!m_valid || rx_ready) begin
                    m_data  = ev_byte[cyc];
                    m_valid = 1'b1;
                    load    = 1'b1;
                end else begin
                    exp_p[1][cyc] = 1'b1;
                end
                if (ev_perr[cyc]) exp_p[2][cyc] = 1'b1;
            end else if (ev_kind[cyc] == 2'd2) begin
                exp_p[0][cyc] = 1'b1;
            end
            if (!load && m_valid && rx_ready) m_valid = 1'b0;
        end
    end

    // Compare process: levels every cycle outside +-1 of a delivery, pulses within +-1 of nominal
    always @(negedge clk) begin
        int e;
        int c;
        bit found;
        if (cyc < N) begin
            hist[0][cyc] = frame_err;
            hist[1][cyc] = overrun_err;
            hist[2][cyc] = parity_err;
            for (int k = 0; k < 3; k++) if (hist[k][cyc]) pcnt[k]++;
            if (rx_valid && !prev_valid) begin
                rises++;
                last_rx  = rx_data;
                rise_cyc = cyc;
            end
            prev_valid = rx_valid;
            if (!reset && !blk[cyc]) begin
                checks++;
                if (rx_valid !== m_valid) begin
                    failures++;
                    $display("FAIL rx_valid_level: got %b expected %b (cycle %0d)", rx_valid, m_valid, cyc);
                end
                if (m_valid) begin
                    checks++;
                    if (rx_data !== m_data) begin
                        failures++;
                        $display("FAIL rx_data_level: got %h expected %h (cycle %0d)", rx_data, m_data, cyc);
                    end
                end
            end
            if (cyc >= 4) begin
                e = cyc - 2;
                for (int k = 0; k < 3; k++) begin
                    if (exp_p[k][e]) begin
                        checks++;
                        found = 1'b0;
                        for (int d = -1; d <= 1; d++) begin
                            if (!found && hist[k][e+d] && !used[k][e+d]) begin
                                used[k][e+d] = 1'b1;
                                found = 1'b1;
                            end
                        end
                        if (!found) begin
                            failures++;
                            $display("FAIL %s_missing: got no pulse expected pulse near cycle %0d", pname[k], e);
                        end
                    end
                end
                c = cyc - 4;
                for (int k = 0; k < 3; k++) begin
                    if (hist[k][c]) begin
                        checks++;
                        if (!used[k][c]) begin
                            failures++;
                            $display("FAIL %s_spurious: got pulse at cycle %0d expected none", pname[k], c);
                        end
                    end
                end
            end
        end
    end

    // Drives one frame; leaves the line at the stop-bit level on return
    task automatic send_frame(input logic [7:0] b, input bit stop, input bit par,
                              input bit expect_it, output int t0);
        int e;
        @(negedge clk);
        rx = 1'b0;
        t0 = cyc;
        if (expect_it) begin
            e = t0 + LAT;
            ev_kind[e] = stop ? 2'd1 : 2'd2;
            ev_byte[e] = b;
`ifdef UART_RX_PARITY_EN
            ev_perr[e] = stop && (par != ^b);
`endif
            blk[e-1] = 1'b1;
            blk[e]   = 1'b1;
            blk[e+1] = 1'b1;
        end
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            repeat (CPB) @(negedge clk);
        end
`ifdef UART_RX_PARITY_EN
        rx = par;
        repeat (CPB) @(negedge clk);
`else
        if (par) rx = 1'b1;
`endif
        rx = stop;
        repeat (CPB) @(negedge clk);
    endtask

    initial begin
        #(10 * 95000);
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int t0;
        int r0;
        int f0, o0, p0;

        repeat (5) @(negedge clk);
        chk("reset_rx_valid", 32'(rx_valid), 32'd0);
        chk("reset_rx_data", 32'(rx_data), 32'd0);
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_frame_err", 32'(frame_err), 32'd0);
        chk("reset_overrun_err", 32'(overrun_err), 32'd0);
        chk("reset_parity_err", 32'(parity_err), 32'd0);
        reset = 1'b0;
        repeat (20) @(negedge clk);

        // Single frame 0x43, consumer always ready
        r0 = rises; f0 = pcnt[0]; o0 = pcnt[1];
        send_frame(8'h43, 1'b1, 1'b0, 1'b1, t0);
        repeat (20) @(negedge clk);
        chk("f43_one_valid", 32'(rises - r0), 32'd1);
        chk("f43_data", 32'(last_rx), 32'h43);
        chk("f43_latency_ok", 32'((rise_cyc - t0 >= LAT - 1) && (rise_cyc - t0 <= LAT + 1)), 32'd1);
        chk("f43_no_frame_err", 32'(pcnt[0] - f0), 32'd0);
        chk("f43_no_overrun", 32'(pcnt[1] - o0), 32'd0);
        chk("f43_busy_idle", 32'(busy), 32'd0);

        // 100-cycle low glitch
        r0 = rises; f0 = pcnt[0];
        @(negedge clk);
        rx = 1'b0;
        repeat (50) @(negedge clk);
        chk("glitch_busy_high", 32'(busy), 32'd1);
        repeat (50) @(negedge clk);
        rx = 1'b1;
        repeat (2 * CPB) @(negedge clk);
        chk("glitch_no_valid", 32'(rises - r0), 32'd0);
        chk("glitch_no_frame_err", 32'(pcnt[0] - f0), 32'd0);
        chk("glitch_busy_idle", 32'(busy), 32'd0);

        // Bad stop bit, line held low, then a good frame
        r0 = rises; f0 = pcnt[0];
        send_frame(8'hA5, 1'b0, 1'b0, 1'b1, t0);
        repeat (1500) @(negedge clk);
        chk("break_busy_high", 32'(busy), 32'd1);
        repeat (1500) @(negedge clk);
        rx = 1'b1;
        repeat (2 * CPB) @(negedge clk);
        chk("a5_one_frame_err", 32'(pcnt[0] - f0), 32'd1);
        chk("a5_no_valid", 32'(rises - r0), 32'd0);
        send_frame(8'h5A, 1'b1, 1'b0, 1'b1, t0);
        repeat (20) @(negedge clk);
        chk("f5a_one_valid", 32'(rises - r0), 32'd1);
        chk("f5a_data", 32'(last_rx), 32'h5A);
        chk("f5a_frame_err_total", 32'(pcnt[0] - f0), 32'd1);

        // Overrun: two back-to-back frames with the consumer stalled
        o0 = pcnt[1];
        rx_ready = 1'b0;
        send_frame(8'h11, 1'b1, 1'b0, 1'b1, t0);
        send_frame(8'h22, 1'b1, 1'b0, 1'b1, t0);
        repeat (20) @(negedge clk);
        chk("ovr_valid_held", 32'(rx_valid), 32'd1);
        chk("ovr_data_held", 32'(rx_data), 32'h11);
        chk("ovr_one_pulse", 32'(pcnt[1] - o0), 32'd1);
        rx_ready = 1'b1;
        repeat (5) @(negedge clk);
        chk("ovr_drained", 32'(rx_valid), 32'd0);
        send_frame(8'h33, 1'b1, 1'b0, 1'b1, t0);
        repeat (20) @(negedge clk);
        chk("f33_data", 32'(last_rx), 32'h33);
        chk("f33_no_new_overrun", 32'(pcnt[1] - o0), 32'd1);

        // Reset in the middle of the data bits of 0xFF
        r0 = rises; f0 = pcnt[0]; o0 = pcnt[1];
        @(negedge clk);
        rx = 1'b0;
        repeat (CPB) @(negedge clk);
        rx = 1'b1;
        repeat (3 * CPB) @(negedge clk);
        chk("rst_mid_busy", 32'(busy), 32'd1);
        reset = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_mid_valid", 32'(rx_valid), 32'd0);
        chk("rst_mid_busy_clear", 32'(busy), 32'd0);
        reset = 1'b0;
        repeat (7 * CPB) @(negedge clk);
        chk("rst_no_spurious", 32'(rises - r0), 32'd0);
        send_frame(8'h0F, 1'b1, 1'b0, 1'b1, t0);
        repeat (20) @(negedge clk);
        chk("f0f_one_valid", 32'(rises - r0), 32'd1);
        chk("f0f_data", 32'(last_rx), 32'h0F);
        chk("f0f_no_errors", 32'((pcnt[0] - f0) + (pcnt[1] - o0)), 32'd0);

`ifdef UART_RX_PARITY_EN
        // Even parity on 0x07: parity bit 1 is correct, 0 is a mismatch
        p0 = pcnt[2];
        send_frame(8'h07, 1'b1, 1'b1, 1'b1, t0);
        repeat (20) @(negedge clk);
        chk("par_ok_data", 32'(last_rx), 32'h07);
        chk("par_ok_no_err", 32'(pcnt[2] - p0), 32'd0);
        r0 = rises;
        send_frame(8'h07, 1'b1, 1'b0, 1'b1, t0);
        repeat (20) @(negedge clk);
        chk("par_bad_delivered", 32'(rises - r0), 32'd1);
        chk("par_bad_data", 32'(last_rx), 32'h07);
        chk("par_bad_one_pulse", 32'(pcnt[2] - p0), 32'd1);
`else
        p0 = pcnt[2];
        repeat (10) @(negedge clk);
        chk("parity_err_never", 32'(pcnt[2] - p0), 32'd0);
`endif

        repeat (20) @(negedge clk);
        chk("final_busy", 32'(busy), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
